// File: rtl/led7_serial_tx.sv
// Serial transmitter for an 8-digit seven-segment board behind a 74HC595-style chain:
// snapshots HEX7..HEX0, shifts 64 bits MSB first, then pulses LATCH. Optional macro: AUTO_REFRESH_EN.
module led7_serial_tx #(
  parameter int CLK_DIV        = 4,
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       START,
  input  logic [7:0] HEX0,
  input  logic [7:0] HEX1,
  input  logic [7:0] HEX2,
  input  logic [7:0] HEX3,
  input  logic [7:0] HEX4,
  input  logic [7:0] HEX5,
  input  logic [7:0] HEX6,
  input  logic [7:0] HEX7,
  output logic       SDO,
  output logic       SCLK,
  output logic       LATCH,
  output logic       BUSY,
  output logic       DONE
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if (CLK_DIV < 1 || REFRESH_CYCLES < 1) begin : gBadParam
    $error("led7_serial_tx: CLK_DIV and REFRESH_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    bit_q, bit_d;
  logic          phase_q, phase_d;
  logic [63:0]   shreg_q, shreg_d;
  logic          sdo_q, sdo_d;
  logic          sclk_q, sclk_d;
  logic          latch_q, latch_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          divEnd;
  logic          startFire;

  assign divEnd = (div_q == DIV_LAST);

`ifdef AUTO_REFRESH_EN
  localparam int RW = $clog2(REFRESH_CYCLES) + 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

  logic [RW-1:0] refresh_q, refresh_d;
  logic          autoFire;

  // Idle time is measured from the DONE cycle; any accepted frame restarts the count.
  assign autoFire  = (state_q == ST_IDLE) && (refresh_q == REFRESH_LAST);
  assign startFire = START | autoFire;

  always_comb begin
    refresh_d = refresh_q + 1'b1;
    if (done_q || state_q != ST_IDLE || startFire) refresh_d = '0;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) refresh_q <= '0;
    else          refresh_q <= refresh_d;
  end
`else
  assign startFire = START;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      shreg_q <= '0;
      sdo_q   <= 1'b1;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      shreg_q <= shreg_d;
      sdo_q   <= sdo_d;
      sclk_q  <= sclk_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // phase_q selects the SCLK-low (0) or SCLK-high (1) half of the current bit.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (startFire) begin
          state_d = ST_SHIFT;
          shreg_d = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (divEnd) begin
          div_d = '0;
          if (phase_q) begin
            phase_d = 1'b0;
            shreg_d = {shreg_q[62:0], 1'b1};
            if (bit_q == 6'd63) begin
              state_d = ST_LATCH;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 6'd1;
            end
          end else begin
            phase_d = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (divEnd) begin
          div_d   = '0;
          state_d = ST_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    sdo_d   = (state_d == ST_SHIFT) ? shreg_d[63] : 1'b1;
    sclk_d  = (state_d == ST_SHIFT) && phase_d;
    latch_d = (state_d == ST_LATCH);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_LATCH) && (state_d == ST_IDLE);
  end

  assign SDO   = sdo_q;
  assign SCLK  = sclk_q;
  assign LATCH = latch_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule
